// File: rtl/audio_play_ctrl.sv
// ---------------------------------------------------------------------------
// audio_play_ctrl
//
// Playback controller for the I2S-style DAC path. Buffers 16-bit samples from
// the SD-card reader in a small synchronous FIFO, generates bclk and the
// left/right word clock dacclk from clock_50M, and presents one sample on
// wav_data per dacclk half-period. Sequences IDLE -> PRIME -> PLAY ->
// STOPPING with a frame-aligned stop, requests refills below a low
// watermark and substitutes silence on underrun.
//
// Ports
//   clock_50M   in   1            sole clock, rising edge
//   rst_n       in   1            asynchronous active-low reset
//   play_en     in   1            1 = start/continue, 0 = stop at frame end
//   flush       in   1            clears the FIFO (honoured in IDLE only)
//   sample_in   in   16           sample from the reader, left first
//   sample_wr   in   1            write strobe for sample_in
//   fifo_full   out  1            FIFO full (registered)
//   fifo_level  out  FIFO_AW+1    current FIFO occupancy
//   refill_req  out  1            registered low-watermark request
//   bclk        out  1            bit clock
//   dacclk      out  1            word clock, 0 = left, 1 = right
//   wav_data    out  16           sample for the current dacclk half-period
//   underrun    out  1            one-cycle pulse when a pop finds FIFO empty
//   playing     out  1            high in PLAY and STOPPING
// ---------------------------------------------------------------------------
module audio_play_ctrl #(
    parameter int BCLK_DIV  = 16,
    parameter int FIFO_AW   = 4,
    parameter int PRIME_LVL = 8,
    parameter int LOW_WM    = 4
) (
    input  logic               clock_50M,
    input  logic               rst_n,
    input  logic               play_en,
    input  logic               flush,
    input  logic [15:0]        sample_in,
    input  logic               sample_wr,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               refill_req,
    output logic               bclk,
    output logic               dacclk,
    output logic [15:0]        wav_data,
    output logic               underrun,
    output logic               playing
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic [FIFO_AW:0]   DEPTH_LVL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   PRIME_LV   = (FIFO_AW+1)'(PRIME_LVL);
    localparam logic [FIFO_AW:0]   LOW_WM_LV  = (FIFO_AW+1)'(LOW_WM);
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [DIV_W-1:0]   DIV_TC     = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_STOPPING
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and pointers
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_d;
    logic               flush_now, fifo_empty, push, pop_ok;

    // Clock generation
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic               run, div_tc, bclk_fall, word_tog;

    // FSM decisions
    logic               pop_req, stop_now;

    assign run       = (state_q == S_PLAY) || (state_q == S_STOPPING);
    assign div_tc    = (div_cnt == DIV_TC);
    assign bclk_fall = run && div_tc && bclk;
    // A word boundary is the bclk fall that wraps the 16-bit counter.
    assign word_tog  = bclk_fall && (bit_cnt == 4'd15);
    assign playing   = run;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // Next-state and pop/stop decisions
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pop_req  = 1'b0;
        stop_now = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (play_en) state_d = S_PRIME;
            end
            S_PRIME: begin
                if (!play_en) begin
                    state_d = S_IDLE;
                end else if (fifo_level >= PRIME_LV) begin
                    // The first left sample is fetched on the entry edge.
                    state_d = S_PLAY;
                    pop_req = 1'b1;
                end
            end
            S_PLAY: begin
                pop_req = word_tog;
                if (!play_en) state_d = S_STOPPING;
            end
            S_STOPPING: begin
                // Right sample still plays; the end of the right half closes
                // the frame and drops back to IDLE without a pop.
                if (word_tog) begin
                    if (dacclk) begin
                        stop_now = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        pop_req  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    assign flush_now  = flush && (state_q == S_IDLE);
    assign fifo_empty = (fifo_level == '0);
    assign pop_ok     = pop_req && !fifo_empty;
    // A write that coincides with a pop is accepted even when full: the pop
    // frees the slot the write lands in (wr_ptr == rd_ptr when full).
    assign push       = sample_wr && !flush_now && (!fifo_full || pop_req);

    always_comb begin
        level_d = fifo_level;
        if (flush_now)
            level_d = '0;
        else if (push && !pop_ok)
            level_d = fifo_level + LVL_ONE;
        else if (!push && pop_ok)
            level_d = fifo_level - LVL_ONE;
    end

    // NOTE: the sample array has no reset; pointers and level define which
    // entries are valid, so clearing the storage would only cost logic.
    always_ff @(posedge clock_50M) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
            refill_req <= 1'b0;
        end else begin
            fifo_level <= level_d;
            fifo_full  <= (level_d == DEPTH_LVL);
            refill_req <= (state_d != S_IDLE) && (level_d < LOW_WM_LV);
            if (flush_now) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)   wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Clock dividers and sample output
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            bclk     <= 1'b0;
            dacclk   <= 1'b0;
            wav_data <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= pop_req && fifo_empty;

            // wav_data changes on the same edge as dacclk, so it is stable
            // for the whole half-period the serializer shifts it out.
            if (pop_req)
                wav_data <= fifo_empty ? 16'h0000 : mem[rd_ptr];
            else if (state_d == S_IDLE)
                wav_data <= 16'h0000;

            if (run && !stop_now) begin
                div_cnt <= div_tc ? '0 : div_cnt + DIV_ONE;
                if (div_tc)    bclk    <= ~bclk;
                if (bclk_fall) bit_cnt <= bit_cnt + 4'd1;
                if (word_tog)  dacclk  <= ~dacclk;
            end else begin
                // IDLE, PRIME and the final stop edge hold the clocks low
                // with the dividers cleared for a clean restart.
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk    <= 1'b0;
                dacclk  <= 1'b0;
            end
        end
    end

endmodule
